// File: rtl/tbird_pkg.sv
// Shared definitions for the Thunderbird tail-light sequencer: state names,
// lamp patterns and the state-to-lamp decode.
package tbird_pkg;

  localparam int LAMP_W = 6;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_L1   = 3'd1,
    ST_L2   = 3'd2,
    ST_L3   = 3'd3,
    ST_R1   = 3'd4,
    ST_R2   = 3'd5,
    ST_R3   = 3'd6,
    ST_LR3  = 3'd7
  } state_e;

  // Bit order is {LC,LB,LA,RA,RB,RC}; lamps light outward from the centre.
  localparam logic [LAMP_W-1:0] LAMPS_IDLE = 6'b000000;
  localparam logic [LAMP_W-1:0] LAMPS_L1   = 6'b001000;
  localparam logic [LAMP_W-1:0] LAMPS_L2   = 6'b011000;
  localparam logic [LAMP_W-1:0] LAMPS_L3   = 6'b111000;
  localparam logic [LAMP_W-1:0] LAMPS_R1   = 6'b000100;
  localparam logic [LAMP_W-1:0] LAMPS_R2   = 6'b000110;
  localparam logic [LAMP_W-1:0] LAMPS_R3   = 6'b000111;
  localparam logic [LAMP_W-1:0] LAMPS_LR3  = 6'b111111;

  function automatic logic [LAMP_W-1:0] lamps_of(input state_e s);
    logic [LAMP_W-1:0] l;
    l = LAMPS_IDLE;
    case (s)
      ST_L1:   l = LAMPS_L1;
      ST_L2:   l = LAMPS_L2;
      ST_L3:   l = LAMPS_L3;
      ST_R1:   l = LAMPS_R1;
      ST_R2:   l = LAMPS_R2;
      ST_R3:   l = LAMPS_R3;
      ST_LR3:  l = LAMPS_LR3;
      default: l = LAMPS_IDLE;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for one asynchronous level input; clears to 0 on reset.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/tbird_taillight_fsm.sv
// Thunderbird tail-light sequencer: synchronised switches drive an 8-state
// Moore FSM that steps once per divider tick; lamps and busy are registered.
module tbird_taillight_fsm
  import tbird_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              left,
  input  logic              right,
  input  logic              hazard,
  output logic [LAMP_W-1:0] lamps,
  output logic              busy
);

  logic l_s, r_s, h_s;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_left (
    .clk (clk), .rst (rst), .d_i (left),   .q_o (l_s)
  );
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_right (
    .clk (clk), .rst (rst), .d_i (right),  .q_o (r_s)
  );
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_hazard (
    .clk (clk), .rst (rst), .d_i (hazard), .q_o (h_s)
  );

  state_e            state_q, state_d;
  logic [LAMP_W-1:0] lamps_q;
  logic              busy_q;

  // A started turn sequence ignores left/right changes; only hazard can cut it short.
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE: begin
        if (h_s || (l_s && r_s)) state_d = ST_LR3;
        else if (l_s)            state_d = ST_L1;
        else if (r_s)            state_d = ST_R1;
        else                     state_d = ST_IDLE;
      end
      ST_L1:   state_d = h_s ? ST_LR3 : ST_L2;
      ST_L2:   state_d = h_s ? ST_LR3 : ST_L3;
      ST_R1:   state_d = h_s ? ST_LR3 : ST_R2;
      ST_R2:   state_d = h_s ? ST_LR3 : ST_R3;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decode the next state so they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lamps_q <= LAMPS_IDLE;
      busy_q  <= 1'b0;
    end else if (tick) begin
      state_q <= state_d;
      lamps_q <= lamps_of(state_d);
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign lamps = lamps_q;
  assign busy  = busy_q;

endmodule
